seq_mul_8bit: RTL and testbench

//  Sequential 8x8 unsigned shift-add multiplier; consumes the sum/cout of one cla_8bit adder per cycle.

---
 rtl/seq_mul_pkg.sv | 18 +
 rtl/cla_8bit.sv | 34 +++
 rtl/seq_mul_8bit.sv | 122 ++++++++++++
 tb/tb_seq_mul_8bit.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/seq_mul_pkg.sv
// Shared encodings and widths for the sequential shift-add multiplier.
package seq_mul_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int unsigned MUL_W     = 8;
  localparam int unsigned PROD_W    = 16;
  localparam int unsigned LAST_ITER = 7;

  typedef enum logic [1:0] {
    StIdle = ST_IDLE,
    StRun  = ST_RUN,
    StDone = ST_DONE
  } state_e;

endpackage

// File: rtl/cla_8bit.sv
// 8-bit carry-lookahead adder built from two 4-bit lookahead groups.
module cla_8bit (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);

  logic [7:0] g;
  logic [7:0] p;
  logic [8:0] c;

  assign g = a & b;
  assign p = a ^ b;

  always_comb begin
    c[0] = cin;
    c[1] = g[0] | (p[0] & c[0]);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c[0]);
    c[5] = g[4] | (p[4] & c[4]);
    c[6] = g[5] | (p[5] & g[4]) | (p[5] & p[4] & c[4]);
    c[7] = g[6] | (p[6] & g[5]) | (p[6] & p[5] & g[4]) | (p[6] & p[5] & p[4] & c[4]);
    c[8] = g[7] | (p[7] & g[6]) | (p[7] & p[6] & g[5]) | (p[7] & p[6] & p[5] & g[4])
         | (p[7] & p[6] & p[5] & p[4] & c[4]);
  end

  assign sum  = p ^ c[7:0];
  assign cout = c[8];

endmodule

// File: rtl/seq_mul_8bit.sv
// Sequential 8x8 unsigned shift-add multiplier with valid/ready on both sides.
// Define MUL_EARLY_TERM_EN to finish as soon as the remaining multiplier bits are zero.
module seq_mul_8bit
  import seq_mul_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_a,
  input  logic [7:0]  in_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_prod,
  output logic        busy
);

  if (WIDTH != MUL_W) begin : g_bad_width
    $error("seq_mul_8bit: WIDTH must be 8");
  end
  if ((2 ** CNT_W) <= WIDTH) begin : g_bad_cnt_w
    $error("seq_mul_8bit: CNT_W too narrow");
  end

  state_e             state_q, state_d;
  logic [MUL_W-1:0]   acc_q, acc_d;
  logic [MUL_W-1:0]   lo_q, lo_d;
  logic [MUL_W-1:0]   mplr_q, mplr_d;
  logic [MUL_W-1:0]   mcand_q, mcand_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [MUL_W-1:0]   add_b;
  logic [MUL_W-1:0]   add_sum;
  logic               add_cout;

  assign add_b = mplr_q[0] ? mcand_q : '0;

  cla_8bit u_cla (
    .a    (acc_q),
    .b    (add_b),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_cout)
  );

`ifdef MUL_EARLY_TERM_EN
  // Right-align the partial product when no multiplier bits remain.
  logic [CNT_W:0] shamt;
  assign shamt = (CNT_W + 1)'(MUL_W) - {1'b0, cnt_q};
`endif

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    lo_d    = lo_q;
    mplr_d  = mplr_q;
    mcand_d = mcand_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          mcand_d = in_a;
          mplr_d  = in_b;
          acc_d   = '0;
          lo_d    = '0;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
`ifdef MUL_EARLY_TERM_EN
        if (mplr_q == '0) begin
          {acc_d, lo_d} = {acc_q, lo_q} >> shamt;
          state_d       = StDone;
        end else
`endif
        begin
          // cout is the ninth bit of the partial sum and shifts into acc.
          {acc_d, lo_d} = {add_cout, add_sum, lo_q[MUL_W-1:1]};
          mplr_d        = mplr_q >> 1;
          cnt_d         = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(LAST_ITER)) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      acc_q   <= '0;
      lo_q    <= '0;
      mplr_q  <= '0;
      mcand_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      lo_q    <= lo_d;
      mplr_q  <= mplr_d;
      mcand_q <= mcand_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign out_prod  = {acc_q, lo_q};

endmodule

// File: tb/tb_seq_mul_8bit.sv
// Directed and random checks for seq_mul_8bit; latency expectations follow MUL_EARLY_TERM_EN.
module tb_seq_mul_8bit;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_prod;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;

  seq_mul_8bit dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_prod  (out_prod),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL timeout: simulation did not finish, got running required done");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", tag, obs, exp);
  endtask

  function automatic int exp_lat(input logic [7:0] b);
`ifdef MUL_EARLY_TERM_EN
    int h;
    h = -1;
    for (int i = 0; i < 8; i++) if (b[i]) h = i;
    if (h < 0) return 1;
    return (h + 2 > 8) ? 8 : h + 2;
`else
    return 8;
`endif
  endfunction

  // Waits for out_valid after the accept edge; returns number of edges, or 99 on timeout.
  task automatic wait_done(output int edges);
    edges = 0;
    while (!out_valid && edges < 20) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    if (!out_valid) edges = 99;
  endtask

  // Called at a negedge. junk keeps in_valid high with other operands while busy.
  task automatic do_mul(input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp,
                        input bit junk, input int hold, input bit chk_lat);
    int w;
    int edges;
    w = 0;
    while (!in_ready && w < 30) begin
      @(negedge clk);
      w++;
    end
    check("in_ready_before_accept", in_ready, 1);
    in_valid  = 1'b1;
    in_a      = a;
    in_b      = b;
    out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    if (junk) begin
      in_a = 8'($urandom);
      in_b = 8'($urandom);
    end else begin
      in_valid = 1'b0;
    end
    wait_done(edges);
    in_valid = 1'b0;
    if (chk_lat) check("latency", edges, exp_lat(b));
    check("prod", out_prod, exp);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("held_valid", out_valid, 1);
      check("held_prod", out_prod, exp);
      check("held_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("valid_drop", out_valid, 0);
    check("idle_again", in_ready, 1);
  endtask

  initial begin
    int edges;
    bit saw_valid;
    logic [7:0] ra, rb;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_prod", out_prod, 16'h0000);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    @(negedge clk);

    do_mul(8'hFF, 8'hFF, 16'hFE01, 1'b0, 0, 1'b1);
    do_mul(8'h0D, 8'h0B, 16'h008F, 1'b0, 0, 1'b1);
    do_mul(8'h12, 8'h34, 16'h03A8, 1'b0, 20, 1'b1);

    // in_valid and out_ready together in DONE: only the exit happens on that edge.
    in_valid = 1'b1;
    in_a     = 8'h80;
    in_b     = 8'h02;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    wait_done(edges);
    check("lat_80x02", edges, exp_lat(8'h02));
    check("prod_80x02", out_prod, 16'h0100);
    in_valid  = 1'b1;
    in_a      = 8'h03;
    in_b      = 8'h05;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("both_hi_valid", out_valid, 0);
    check("both_hi_idle", in_ready, 1);
    check("both_hi_busy", busy, 0);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("accept_next_edge", busy, 1);
    wait_done(edges);
    check("prod_03x05", out_prod, 16'h000F);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;

    // Reset in the middle of RUN.
    in_valid = 1'b1;
    in_a     = 8'hAA;
    in_b     = 8'h55;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_in_ready", in_ready, 1);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_prod", out_prod, 16'h0000);
    check("midrst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    saw_valid = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid) saw_valid = 1'b1;
    end
    check("no_valid_after_rst", saw_valid, 0);
    do_mul(8'h03, 8'h03, 16'h0009, 1'b0, 0, 1'b1);

    // Early-termination latency vectors (latency expectation is 8 without the macro).
    do_mul(8'h5A, 8'h01, 16'h005A, 1'b0, 0, 1'b1);
    do_mul(8'h77, 8'h00, 16'h0000, 1'b0, 0, 1'b1);
    do_mul(8'h01, 8'h80, 16'h0080, 1'b0, 0, 1'b1);

    for (int n = 0; n < 1000; n++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      do_mul(ra, rb, 16'(ra) * 16'(rb), 1'b1, int'($urandom_range(0, 3)), 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
